sccb_write_arbiter: RTL and testbench

- Shares the single camera SCCB/I2C sender between NUM_REQ register-write requesters, e.g. the power-up register table and runtime exposure/gain tweaks.
- Enforces a power-up hold-off, round-robin arbitration with optional burst lock, a post-write settle gap, and a taken-timeout with recovery.
- Sits between the requesters and the sender's send/taken interface, inside the camera controller.

---
 rtl/sccb_write_arbiter_pkg.sv | 16 +
 rtl/sccb_write_arbiter_if.sv | 31 +++
 rtl/sccb_write_arbiter_rr_picker.sv | 27 ++
 rtl/sccb_write_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sccb_write_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/sccb_write_arbiter_pkg.sv
// Shared types and constants for the SCCB write arbiter and its helpers.
package sccb_write_arbiter_pkg;

   localparam int         CMD_W             = 16;
   localparam logic [7:0] DEFAULT_CAMERA_ID = 8'h42;
   localparam int         REG_HI            = 15;
   localparam int         VAL_HI            = 7;

   typedef enum logic [1:0] {
      POWERUP = 2'd0,
      IDLE    = 2'd1,
      SEND    = 2'd2,
      GAP     = 2'd3
   } state_t;

endpackage

// File: rtl/sccb_write_arbiter_if.sv
// Requester-side and sender-side signals of the SCCB write arbiter.
interface sccb_write_arbiter_if #(
   parameter int NUM_REQ = 2
);
   import sccb_write_arbiter_pkg::*;

   // Requester i holds req_valid[i] and its req_data slot until req_ready[i] or
   // req_err[i] pulses for one cycle; send is held until the sender pulses taken.
   logic [NUM_REQ-1:0]       req_valid;
   logic [CMD_W*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]       req_lock;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0]       req_err;
   logic [NUM_REQ-1:0]       grant;
   logic                     send;
   logic [7:0]               id;
   logic [7:0]               reg_addr;
   logic [7:0]               value;
   logic                     taken;

   modport master (
      input  req_valid, req_data, req_lock, taken,
      output req_ready, req_err, grant, send, id, reg_addr, value
   );

   modport slave (
      output req_valid, req_data, req_lock, taken,
      input  req_ready, req_err, grant, send, id, reg_addr, value
   );

endinterface

// File: rtl/sccb_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after ptr, with wrap.
module rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic               any
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      winner = '0;
      idx    = '0;
      any    = |req;
      // ptr itself is searched last so the previous owner has lowest priority
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
         if (req[idx] && (winner == '0)) begin
            winner[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sccb_write_arbiter.sv
// Arbitrates camera register writes from NUM_REQ requesters onto one SCCB sender,
// with power-up hold-off, post-write gap, burst lock and taken timeout.
module sccb_write_arbiter
   import sccb_write_arbiter_pkg::*;
#(
   parameter int         NUM_REQ        = 2,
   parameter logic [7:0] CAMERA_ID      = DEFAULT_CAMERA_ID,
   parameter int         POWERUP_CYCLES = 65536,
   parameter int         GAP_CYCLES     = 1024,
   parameter int         TIMEOUT_CYCLES = 262144
) (
   input  logic                  clk,
   input  logic                  reset_n,
   sccb_write_arbiter_if.master  bus,
   output logic                  startup_done,
   output logic                  busy,
   output state_t                fsm_state
);

   localparam int PTR_W   = $clog2(NUM_REQ);
   localparam int GAP_EFF = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;

   state_t             state_q, state_n;
   logic [31:0]        cnt_q, cnt_n;
   logic [PTR_W-1:0]   ptr_q, ptr_n;
   logic [NUM_REQ-1:0] grant_q, grant_n;
   logic               send_q, send_n;
   logic [7:0]         reg_q, reg_n;
   logic [7:0]         val_q, val_n;
   logic [NUM_REQ-1:0] ready_q, ready_n;
   logic [NUM_REQ-1:0] err_q, err_n;
   logic               done_q, done_n;

   logic [NUM_REQ-1:0] pick;
   logic               pick_any;
   logic [PTR_W-1:0]   pick_idx;
   logic [CMD_W-1:0]   pick_cmd;
   logic [CMD_W-1:0]   own_cmd;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_picker (
      .req    (bus.req_valid),
      .ptr    (ptr_q),
      .winner (pick),
      .any    (pick_any)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) begin
            pick_idx = PTR_W'(i);
         end
      end
   end

   assign pick_cmd = bus.req_data[int'(pick_idx)*CMD_W +: CMD_W];
   // The pointer always names the current owner, so it also indexes lock regrants
   assign own_cmd  = bus.req_data[int'(ptr_q)*CMD_W +: CMD_W];

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q + 32'd1;
      ptr_n   = ptr_q;
      grant_n = grant_q;
      send_n  = send_q;
      reg_n   = reg_q;
      val_n   = val_q;
      ready_n = '0;
      err_n   = '0;
      done_n  = done_q;
      case (state_q)
         POWERUP: begin
            if (cnt_q == 32'(POWERUP_CYCLES - 1)) begin
               state_n = IDLE;
               cnt_n   = '0;
               done_n  = 1'b1;
            end
         end
         IDLE: begin
            cnt_n = '0;
            if (pick_any) begin
               state_n = SEND;
               grant_n = pick;
               ptr_n   = pick_idx;
               send_n  = 1'b1;
               reg_n   = pick_cmd[REG_HI -: 8];
               val_n   = pick_cmd[VAL_HI -: 8];
            end
         end
         SEND: begin
            if (bus.taken) begin
               state_n = GAP;
               cnt_n   = '0;
               send_n  = 1'b0;
               ready_n = grant_q;
            end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
               state_n = GAP;
               cnt_n   = '0;
               send_n  = 1'b0;
               err_n   = grant_q;
            end
         end
         GAP: begin
            if (cnt_q == 32'(GAP_EFF - 1)) begin
               cnt_n = '0;
               if (bus.req_lock[ptr_q] && bus.req_valid[ptr_q]) begin
                  state_n = SEND;
                  send_n  = 1'b1;
                  reg_n   = own_cmd[REG_HI -: 8];
                  val_n   = own_cmd[VAL_HI -: 8];
               end else begin
                  state_n = IDLE;
                  grant_n = '0;
               end
            end
         end
         default: begin
            state_n = POWERUP;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= POWERUP;
         cnt_q   <= '0;
         ptr_q   <= PTR_W'(NUM_REQ - 1);
         grant_q <= '0;
         send_q  <= 1'b0;
         reg_q   <= '0;
         val_q   <= '0;
         ready_q <= '0;
         err_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         ptr_q   <= ptr_n;
         grant_q <= grant_n;
         send_q  <= send_n;
         reg_q   <= reg_n;
         val_q   <= val_n;
         ready_q <= ready_n;
         err_q   <= err_n;
         done_q  <= done_n;
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.req_err   = err_q;
   assign bus.grant     = grant_q;
   assign bus.send      = send_q;
   assign bus.id        = CAMERA_ID;
   assign bus.reg_addr  = reg_q;
   assign bus.value     = val_q;
   assign startup_done  = done_q;
   assign busy          = (state_q != IDLE);
   assign fsm_state     = state_q;

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// Directed bench for sccb_write_arbiter with short power-up, gap and timeout.
module tb_sccb_write_arbiter;
   import sccb_write_arbiter_pkg::*;

   localparam int NUM_REQ = 2;

   logic   clk;
   logic   reset_n;
   logic   startup_done;
   logic   busy;
   state_t fsm_state;

   int n_cmp = 0;
   int n_bad = 0;

   sccb_write_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   sccb_write_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .CAMERA_ID      (8'h42),
      .POWERUP_CYCLES (16),
      .GAP_CYCLES     (4),
      .TIMEOUT_CYCLES (32)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus),
      .startup_done (startup_done),
      .busy         (busy),
      .fsm_state    (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic wait_send(input int exp_n, input logic [1:0] exp_grant, input logic [15:0] exp_cmd);
      int n;
      n = 0;
      while (bus.send !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("send_seen", 32'(bus.send), 32'd1);
      check("send_latency", 32'(n), 32'(exp_n));
      check("grant", 32'(bus.grant), 32'(exp_grant));
      check("cmd", {16'h0, bus.reg_addr, bus.value}, 32'(exp_cmd));
   endtask

   task automatic take(input int d, input logic [1:0] exp_grant, input logic [15:0] exp_cmd);
      repeat (d) @(negedge clk);
      check("hold_send", 32'(bus.send), 32'd1);
      check("hold_cmd", {16'h0, bus.reg_addr, bus.value}, 32'(exp_cmd));
      bus.taken = 1'b1;
      @(negedge clk);
      bus.taken = 1'b0;
      check("ready_pulse", 32'(bus.req_ready), 32'(exp_grant));
      check("no_err", 32'(bus.req_err), 32'd0);
      check("send_drop", 32'(bus.send), 32'd0);
      check("grant_in_gap", 32'(bus.grant), 32'(exp_grant));
      @(negedge clk);
      check("ready_clear", 32'(bus.req_ready), 32'd0);
   endtask

   initial begin
      int n;
      reset_n           = 1'b0;
      bus.req_valid     = 2'b01;
      bus.req_data      = {16'hABCD, 16'h1234};
      bus.req_lock      = 2'b00;
      bus.taken         = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_send", 32'(bus.send), 32'd0);
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_err", 32'(bus.req_err), 32'd0);
      check("rst_reg", 32'(bus.reg_addr), 32'd0);
      check("rst_val", 32'(bus.value), 32'd0);
      check("rst_done", 32'(startup_done), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_state", 32'(fsm_state), 32'(POWERUP));
      check("id", 32'(bus.id), 32'h42);
      reset_n = 1'b1;

      // power-up hold-off with requester 0 valid from the start
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (bus.send !== 1'b0) check("pu_no_send", 32'(bus.send), 32'd0);
         if (i == 15) check("pu_done_lo", 32'(startup_done), 32'd0);
         if (i == 16) begin
            check("pu_done_hi", 32'(startup_done), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
         end
      end
      wait_send(1, 2'b01, 16'h1234);
      check("send_busy", 32'(busy), 32'd1);
      bus.req_valid = 2'b00;
      bus.req_data  = {16'hABCD, 16'hFFFF};
      take(3, 2'b01, 16'h1234);

      // round-robin alternation, both valid, no lock
      bus.req_valid = 2'b11;
      bus.req_data  = {16'h3C4D, 16'h1A2B};
      wait_send(4, 2'b10, 16'h3C4D);
      take(3, 2'b10, 16'h3C4D);
      wait_send(4, 2'b01, 16'h1A2B);
      take(3, 2'b01, 16'h1A2B);
      wait_send(4, 2'b10, 16'h3C4D);
      take(3, 2'b10, 16'h3C4D);

      // lock burst of three writes from requester 0
      bus.req_lock = 2'b01;
      bus.req_data = {16'h3C4D, 16'h5501};
      wait_send(4, 2'b01, 16'h5501);
      take(3, 2'b01, 16'h5501);
      bus.req_data = {16'h3C4D, 16'h5502};
      wait_send(3, 2'b01, 16'h5502);
      take(3, 2'b01, 16'h5502);
      bus.req_data = {16'h3C4D, 16'h5503};
      wait_send(3, 2'b01, 16'h5503);
      take(3, 2'b01, 16'h5503);
      bus.req_lock = 2'b00;
      wait_send(4, 2'b10, 16'h3C4D);
      take(3, 2'b10, 16'h3C4D);

      // timeout without taken
      bus.req_valid = 2'b01;
      bus.req_data  = {16'h3C4D, 16'h7788};
      wait_send(4, 2'b01, 16'h7788);
      n = 0;
      while (bus.send === 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("to_len", 32'(n), 32'd32);
      check("to_err", 32'(bus.req_err), 32'd1);
      check("to_no_ready", 32'(bus.req_ready), 32'd0);
      check("to_grant", 32'(bus.grant), 32'd1);
      bus.taken = 1'b1;
      @(negedge clk);
      bus.taken = 1'b0;
      check("gap_taken_ready", 32'(bus.req_ready), 32'd0);
      check("to_err_clear", 32'(bus.req_err), 32'd0);
      wait_send(4, 2'b01, 16'h7788);

      // taken on the exact timeout cycle; late data change ignored
      bus.req_data = {16'h3C4D, 16'h0000};
      repeat (31) @(negedge clk);
      check("edge_send", 32'(bus.send), 32'd1);
      check("edge_cmd", {16'h0, bus.reg_addr, bus.value}, 32'h7788);
      bus.taken = 1'b1;
      @(negedge clk);
      bus.taken = 1'b0;
      check("edge_ready", 32'(bus.req_ready), 32'd1);
      check("edge_err", 32'(bus.req_err), 32'd0);
      check("edge_send_drop", 32'(bus.send), 32'd0);
      @(negedge clk);
      bus.req_data = {16'h3C4D, 16'h99AA};

      // reset during SEND
      wait_send(4, 2'b01, 16'h99AA);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("mid_rst_send", 32'(bus.send), 32'd0);
      check("mid_rst_grant", 32'(bus.grant), 32'd0);
      check("mid_rst_done", 32'(startup_done), 32'd0);
      check("mid_rst_state", 32'(fsm_state), 32'(POWERUP));
      repeat (16) @(negedge clk);
      check("re_pu_done", 32'(startup_done), 32'd1);
      wait_send(1, 2'b01, 16'h99AA);
      take(3, 2'b01, 16'h99AA);

      // report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
